// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Single-outstanding instruction fetch unit. Issues one word read at a time,
//   holds the returned instruction for decode until the core acknowledges it,
//   then computes the next fetch address (sequential or branch target).
//   A misaligned next target parks the unit in a sticky FAULT state until reset.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   imem_req        : fetch request valid (o)
//   imem_addr       : fetch byte address, word aligned (o)
//   imem_ready      : memory accepts request this cycle (i)
//   imem_rvalid     : read data valid (i)
//   imem_rdata      : instruction word (i)
//   instr, opcode   : held instruction and its [6:0] field (o)
//   pc, pc_plus4    : address of held instruction and pc + 4 (o)
//   instr_valid     : instr/pc valid for decode (o)
//   instr_ack       : core retires held instruction (i)
//   pcscr, imm_ext  : branch taken flag and sign-extended offset (i)
//   fetch_fault     : sticky misaligned-target flag (o)
//   dbg_state_o     : current FSM state, for observation (o)
//
// Handshake: a request transfers on a cycle where imem_req=1 and imem_ready=1;
// imem_addr is held stable while imem_req=1 and imem_ready=0. The response is
// a single imem_rvalid pulse, accepted only while waiting for it. The held
// instruction transfers to the core on a cycle where instr_valid=1 and
// instr_ack=1; it stays stable until then.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        pcscr,
  input  logic [31:0] imm_ext,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] next_pc;

  // Both additions wrap modulo 2^32 by construction of the 32-bit result.
  assign next_pc = pcscr ? (pc_q + imm_ext) : (pc_q + 32'd4);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    case (state_q)
      S_REQ: begin
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            fetch_pc_d = next_pc;
            state_d    = S_REQ;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      instr_q    <= 32'd0;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
    end
  end

  // Request is masked while rst is high so nothing is issued during reset,
  // whatever state the register holds before the reset edge.
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = (state_q == S_HOLD);
  assign fetch_fault = fault_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch: a table of fetch/ack vectors walked
//   in order, hand sequences for fault, reset-in-WAIT and stray responses,
//   and a short randomized sequential run. Expected {pc, instr} pairs are
//   queued when a response is driven and checked when instr_valid rises.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack;
  logic        pcscr;
  logic [31:0] imm_ext;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .pcscr       (pcscr),
    .imm_ext     (imm_ext),
    .fetch_fault (fetch_fault),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rv_dly;
    logic        br;
    logic [31:0] imm;
    logic [31:0] nxt;
    logic        flt;
  } vec_t;

  vec_t        vecs[9];
  logic [63:0] exp_q[$];
  int          n_vec;
  int          n_err;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst         = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    instr_ack   = 1'b0;
    pcscr       = 1'b0;
    tick;
    chk("rst_no_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("rst_no_req2", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    rst = 1'b0;
    tick;
    chk("rst_first_req", {31'd0, imem_req}, 32'd1);
    chk("rst_first_addr", imem_addr, RESET_PC);
  endtask

  // driver: one complete fetch transaction with given stall lengths
  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata,
                       input int rdy_dly, input int rv_dly);
    int          t;
    logic [63:0] e;
    t = 0;
    while (imem_req !== 1'b1 && t < 20) begin
      tick;
      t++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ready = 1'b0;
      tick;
      chk("stall_req_held", {31'd0, imem_req}, 32'd1);
      chk("stall_addr_stable", imem_addr, addr);
    end
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    chk("wait_no_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      tick;
      chk("wait_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_no_req2", {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    exp_q.push_back({addr, rdata});
    tick;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("resp_valid", {31'd0, instr_valid}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("resp_pc", pc, e[63:32]);
      chk("resp_instr", instr, e[31:0]);
      chk("resp_opcode", {25'd0, opcode}, {25'd0, e[6:0]});
      chk("resp_pc_plus4", pc_plus4, e[63:32] + 32'd4);
    end
  endtask

  // driver: hold for a cycle (with a stray response), then acknowledge
  task automatic ack(input logic br, input logic [31:0] imm,
                     input logic [31:0] nxt, input logic flt);
    logic [31:0] pc0;
    logic [31:0] i0;
    pc0         = pc;
    i0          = instr;
    imem_rvalid = 1'b1;
    imem_rdata  = ~i0;
    tick;
    imem_rvalid = 1'b0;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", instr, i0);
    chk("hold_pc", pc, pc0);
    chk("hold_no_req", {31'd0, imem_req}, 32'd0);
    instr_ack = 1'b1;
    pcscr     = br;
    imm_ext   = imm;
    tick;
    instr_ack = 1'b0;
    pcscr     = 1'b0;
    imm_ext   = $urandom;
    chk("ack_valid_drop", {31'd0, instr_valid}, 32'd0);
    if (flt) begin
      chk("fault_set", {31'd0, fetch_fault}, 32'd1);
      chk("fault_no_req", {31'd0, imem_req}, 32'd0);
    end else begin
      chk("ack_next_req", {31'd0, imem_req}, 32'd1);
      chk("ack_next_addr", imem_addr, nxt);
      chk("ack_no_fault", {31'd0, fetch_fault}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    instr_ack   = 1'b0;
    pcscr       = 1'b0;
    imm_ext     = 32'd0;

    //          addr          rdata         rdy rv br  imm           next          flt
    vecs[0] = '{32'h0000_0000, 32'h00A0_0093, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0000_0013, 3, 5, 1'b1, 32'h0000_000C, 32'h0000_0010, 1'b0};
    vecs[2] = '{32'h0000_0010, 32'h0020_8133, 0, 1, 1'b0, 32'h0000_0000, 32'h0000_0014, 1'b0};
    vecs[3] = '{32'h0000_0014, 32'hFE00_0EE3, 1, 0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0};
    vecs[4] = '{32'h0000_0010, 32'h0000_006F, 0, 0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008, 1'b0};
    vecs[5] = '{32'h0000_0008, 32'h1234_5037, 2, 2, 1'b1, 32'hFFFF_FFF4, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0017, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0010_0073, 1, 3, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b0};
    vecs[8] = '{32'h0000_0020, 32'h0000_0063, 0, 0, 1'b1, 32'h0000_0002, 32'h0000_0022, 1'b1};

    do_reset;
    for (int v = 0; v < 9; v++) begin
      fetch(vecs[v].addr, vecs[v].rdata, vecs[v].rdy_dly, vecs[v].rv_dly);
      ack(vecs[v].br, vecs[v].imm, vecs[v].nxt, vecs[v].flt);
    end

    // FAULT is sticky: memory and core activity must not move it
    for (int i = 0; i < 4; i++) begin
      imem_ready  = 1'b1;
      imem_rvalid = 1'b1;
      instr_ack   = 1'b1;
      pcscr       = 1'b1;
      tick;
      chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      chk("fault_req_low", {31'd0, imem_req}, 32'd0);
      chk("fault_valid_low", {31'd0, instr_valid}, 32'd0);
    end
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    instr_ack   = 1'b0;
    pcscr       = 1'b0;
    do_reset;

    // reset mid-transaction, then a stray response before acceptance
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    chk("mid_wait_no_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    tick;
    chk("mid_rst_no_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    tick;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      instr_ack   = 1'b1;
      tick;
      chk("stray_valid_low", {31'd0, instr_valid}, 32'd0);
      chk("stray_req_held", {31'd0, imem_req}, 32'd1);
      chk("stray_addr", imem_addr, RESET_PC);
      chk("stray_instr", instr, 32'd0);
    end
    imem_rvalid = 1'b0;
    instr_ack   = 1'b0;
    fetch(RESET_PC, 32'h0000_0513, 0, 0);
    ack(1'b0, 32'h0, RESET_PC + 32'd4, 1'b0);

    // randomized sequential run against a running-pc model
    exp_pc = RESET_PC + 32'd4;
    for (int k = 0; k < 6; k++) begin
      fetch(exp_pc, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      ack(1'b0, $urandom, exp_pc + 32'd4, 1'b0);
      exp_pc = exp_pc + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
